// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: hold/repeat state
// encoding, default 100 MHz timing constants and counter sizing helpers.
package btn_pkg;

    // Per-channel hold/repeat state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // Default cycle counts at 100 MHz.
    localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;   // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;  // 0.5 s
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 0.1 s

    // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce counter and hold/repeat
// FSM. The press/release pulses are decided from the same condition that
// flips the debounced level, so a pulse shares its cycle with the level edge.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned DB_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned TM_W = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_CYCLES - 1);
    localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
    localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYCLES - 1);

    logic            sync_a;
    logic            sync_b;
    logic [DB_W-1:0] db_cnt;
    logic [TM_W-1:0] timer;
    btn_state_t      state;

    logic flip;
    logic rise;
    logic fall;

    // The level changes on the next edge exactly when these are high.
    assign flip = (sync_b != level) && (db_cnt == DB_LAST);
    assign rise = flip & sync_b;
    assign fall = flip & ~sync_b;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: count consecutive disagreeing cycles, adopt the new value after STABLE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync_b == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync_b;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Hold/repeat FSM with registered pulses; a falling level wins over a repeat tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        timer       <= '0;
                        state       <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        release_pulse <= 1'b1;
                        timer         <= '0;
                        state         <= ST_IDLE;
                    end else if (REPEAT_EN) begin
                        if (timer == HOLD_LAST) begin
                            press_pulse <= 1'b1;
                            timer       <= '0;
                            state       <= ST_REPEAT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        release_pulse <= 1'b1;
                        timer         <= '0;
                        state         <= ST_IDLE;
                    end else if (timer == REP_LAST) begin
                        press_pulse <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Nexys4 push-button conditioner: N_BTN independent channels, each producing
// a debounced level plus single-cycle press (with optional auto-repeat) and
// release pulses. All outputs are registered inside the channels.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN         = 5,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .raw          (btn_raw[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Two instances share clock and reset:
// dut_a with auto-repeat, dut_b without. Every press/release pulse seen is
// logged as {dut, cycle, kind, bit}; each step pushes the events it expects
// and the log is compared against them in order.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int SC = 4;
    localparam int HC = 20;
    localparam int RC = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw_a, level_a, press_a, rel_a;
    logic [N-1:0] raw_b, level_b, press_b, rel_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];

    button_conditioner #(
        .N_BTN(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_a),
        .btn_level(level_a), .btn_press(press_a), .btn_release(rel_a)
    );

    button_conditioner #(
        .N_BTN(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_b),
        .btn_level(level_b), .btn_press(press_b), .btn_release(rel_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] ev(input bit d, input int c, input bit rel, input int i);
        return {d, c[22:0], rel, i[2:0]};
    endfunction

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (press_a[i]) obs_q.push_back(ev(1'b0, cyc, 1'b0, i));
                if (rel_a[i])   obs_q.push_back(ev(1'b0, cyc, 1'b1, i));
            end
            for (int i = 0; i < N; i++) begin
                if (press_b[i]) obs_q.push_back(ev(1'b1, cyc, 1'b0, i));
                if (rel_b[i])   obs_q.push_back(ev(1'b1, cyc, 1'b1, i));
            end
            checks++;
            assert (((press_a & rel_a) | (press_b & rel_b)) === '0)
            else begin
                errors++;
                $error("FAIL press_release_overlap cycle=%0d observed=%b/%b expected=0", cyc,
                       press_a & rel_a, press_b & rel_b);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected events and compare them with the logged ones in order
    task automatic check_sb(input string tag);
        logic [27:0] e;
        logic [27:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            checks++;
            assert (o === e)
            else begin
                errors++;
                $error("FAIL %s event observed=d%0d/c%0d/r%0d/b%0d expected=d%0d/c%0d/r%0d/b%0d",
                       tag, o[27], o[26:4], o[3], o[2:0], e[27], e[26:4], e[3], e[2:0]);
            end
        end
        checks++;
        assert (obs_q.size() == 0)
        else begin
            errors++;
            $error("FAIL %s extra_events observed=%0d expected=0", tag, obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        int c;
        int t0;
        int r;

        rst_n = 1'b0;
        raw_a = '0;
        raw_b = '0;
        step(3);
        check_eq("reset_level", level_a | level_b, '0);
        check_eq("reset_press", press_a | press_b, '0);
        check_eq("reset_release", rel_a | rel_b, '0);
        rst_n = 1'b1;
        step(5);

        // Clean press on bit 0, held 10 cycles
        c = cyc;
        raw_a[0] = 1'b1;
        exp_q.push_back(ev(1'b0, c + 6, 1'b0, 0));
        wait_cyc(c + 5);
        check_eq("clean_level_pre", level_a, 5'b00000);
        wait_cyc(c + 6);
        check_eq("clean_level_rise", level_a, 5'b00001);
        wait_cyc(c + 10);
        raw_a[0] = 1'b0;
        exp_q.push_back(ev(1'b0, c + 16, 1'b1, 0));
        wait_cyc(c + 15);
        check_eq("clean_level_hold", level_a, 5'b00001);
        wait_cyc(c + 16);
        check_eq("clean_level_fall", level_a, 5'b00000);
        step(4 + $urandom_range(0, 5));
        check_sb("clean");

        // Bounce on bit 1: toggles every 2 cycles, then settles high
        for (int k = 0; k < 10; k++) begin
            raw_a[1] = ~raw_a[1];
            step(2);
        end
        c = cyc;
        raw_a[1] = 1'b1;
        exp_q.push_back(ev(1'b0, c + 6, 1'b0, 1));
        wait_cyc(c + 5);
        check_eq("bounce_level_pre", level_a, 5'b00000);
        wait_cyc(c + 6);
        check_eq("bounce_level_rise", level_a, 5'b00010);
        step(4);
        c = cyc;
        raw_a[1] = 1'b0;
        exp_q.push_back(ev(1'b0, c + 6, 1'b1, 1));
        step(10 + $urandom_range(0, 5));
        check_sb("bounce");

        // Auto-repeat on bit 2; level falls on the cycle a repeat tick would land
        c = cyc;
        raw_a[2] = 1'b1;
        t0 = c + 6;
        exp_q.push_back(ev(1'b0, t0,      1'b0, 2));
        exp_q.push_back(ev(1'b0, t0 + 20, 1'b0, 2));
        exp_q.push_back(ev(1'b0, t0 + 28, 1'b0, 2));
        exp_q.push_back(ev(1'b0, t0 + 36, 1'b0, 2));
        exp_q.push_back(ev(1'b0, t0 + 44, 1'b0, 2));
        exp_q.push_back(ev(1'b0, t0 + 52, 1'b0, 2));
        wait_cyc(t0 + 54);
        raw_a[2] = 1'b0;
        exp_q.push_back(ev(1'b0, t0 + 60, 1'b1, 2));
        wait_cyc(t0 + 59);
        check_eq("repeat_level_hold", level_a, 5'b00100);
        step(12);
        check_sb("repeat");

        // Same hold on the instance without auto-repeat
        c = cyc;
        raw_b[2] = 1'b1;
        t0 = c + 6;
        exp_q.push_back(ev(1'b1, t0, 1'b0, 2));
        wait_cyc(t0 + 54);
        raw_b[2] = 1'b0;
        exp_q.push_back(ev(1'b1, t0 + 60, 1'b1, 2));
        step(14);
        check_sb("no_repeat");

        // Reset asserted during a repeat pulse on bit 3, button kept held
        c = cyc;
        raw_a[3] = 1'b1;
        t0 = c + 6;
        exp_q.push_back(ev(1'b0, t0,      1'b0, 3));
        exp_q.push_back(ev(1'b0, t0 + 20, 1'b0, 3));
        wait_cyc(t0 + 20);
        check_eq("rst_press_before", press_a, 5'b01000);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_level", level_a, 5'b00000);
        check_eq("rst_async_press", press_a, 5'b00000);
        check_eq("rst_async_release", rel_a, 5'b00000);
        check_sb("reset_pre");
        step(3);
        r = cyc;
        rst_n = 1'b1;
        exp_q.push_back(ev(1'b0, r + 6, 1'b0, 3));
        wait_cyc(r + 5);
        check_eq("rst_relevel_pre", level_a, 5'b00000);
        wait_cyc(r + 6);
        check_eq("rst_relevel_rise", level_a, 5'b01000);
        wait_cyc(r + 8);
        raw_a[3] = 1'b0;
        exp_q.push_back(ev(1'b0, r + 14, 1'b1, 3));
        step(10);
        check_sb("reset_post");

        // Simultaneous press on bits 0, 2, 4
        c = cyc;
        raw_a = 5'b10101;
        exp_q.push_back(ev(1'b0, c + 6, 1'b0, 0));
        exp_q.push_back(ev(1'b0, c + 6, 1'b0, 2));
        exp_q.push_back(ev(1'b0, c + 6, 1'b0, 4));
        wait_cyc(c + 6);
        check_eq("simul_press", press_a, 5'b10101);
        check_eq("simul_level", level_a, 5'b10101);
        wait_cyc(c + 8);
        raw_a = 5'b00000;
        exp_q.push_back(ev(1'b0, c + 14, 1'b1, 0));
        exp_q.push_back(ev(1'b0, c + 14, 1'b1, 2));
        exp_q.push_back(ev(1'b0, c + 14, 1'b1, 4));
        step(10);
        check_sb("simul");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
